// File: rtl/mips_fetch_unit.sv
// rtl/mips_fetch_unit.sv - MIPS instruction-fetch stage (IDLE/FETCH/HOLD)
// Optional fetch timeout with NOP injection: define FETCH_TIMEOUT_EN.
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_err
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t      state, state_nx;
  logic [31:0] pc_nx, instr_nx;
  logic        valid_nx;
  logic [31:0] target_al;

  // Low target bits are masked rather than sliced off so a misaligned
  // target still lands on the enclosing word.
  assign target_al = redirect_target & ~32'h0000_0003;
  assign pc_plus4  = pc + 32'd4;
  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;
  assign op        = instr[31:26];
  assign funct     = instr[5:0];

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt, cnt_nx;
  logic          err_nx;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt       <= '0;
      fetch_err <= 1'b0;
    end else begin
      cnt       <= cnt_nx;
      fetch_err <= err_nx;
    end
  end
`else
  assign fetch_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      instr       <= instr_nx;
      instr_valid <= valid_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    instr_nx = instr;
    valid_nx = instr_valid;
`ifdef FETCH_TIMEOUT_EN
    cnt_nx   = cnt;
    err_nx   = fetch_err;
`endif
    case (state)
      IDLE: begin
        state_nx = FETCH;
`ifdef FETCH_TIMEOUT_EN
        cnt_nx   = '0;
`endif
      end
      FETCH: begin
        // Redirect takes priority; any ack data in the same cycle is dropped.
        if (redirect) begin
          pc_nx    = target_al;
`ifdef FETCH_TIMEOUT_EN
          cnt_nx   = '0;
`endif
        end else if (imem_ack) begin
          instr_nx = imem_rdata;
          valid_nx = 1'b1;
          state_nx = HOLD;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (cnt == TO_LAST) begin
          err_nx   = 1'b1;
          instr_nx = 32'h0000_0000;
          valid_nx = 1'b1;
          state_nx = HOLD;
        end else begin
          cnt_nx   = cnt + 1'b1;
        end
`endif
      end
      HOLD: begin
        if (redirect) begin
          pc_nx    = target_al;
          valid_nx = 1'b0;
          state_nx = FETCH;
`ifdef FETCH_TIMEOUT_EN
          cnt_nx   = '0;
`endif
        end else if (!stall) begin
          pc_nx    = pc_plus4;
          valid_nx = 1'b0;
          state_nx = FETCH;
`ifdef FETCH_TIMEOUT_EN
          cnt_nx   = '0;
`endif
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb/tb_mips_fetch_unit.sv - scoreboard bench for mips_fetch_unit
module tb_mips_fetch_unit;

  localparam logic [31:0] RPC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        instr_valid;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_err;

  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] sb_q[$];
  logic [31:0] exp_pc;
  logic        prev_valid = 1'b0;

  mips_fetch_unit #(.RESET_PC(RPC), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_target(redirect_target),
    .instr_valid(instr_valid), .instr(instr), .op(op), .funct(funct),
    .pc(pc), .pc_plus4(pc_plus4), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 50) begin
      step();
      n++;
    end
    check("req_wait", {63'd0, imem_req}, 64'd1);
  endtask

  // Deliver one instruction after ws wait states, hold it st cycles, then release.
  task automatic fetch_one(input logic [31:0] data, input int ws, input int st);
    wait_req();
    check("fetch_addr", {32'd0, imem_addr}, {32'd0, exp_pc});
    repeat (ws) begin
      step();
      check("ws_req", {63'd0, imem_req}, 64'd1);
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    sb_q.push_back({exp_pc, data});
    step();
    check("ack_valid", {63'd0, instr_valid}, 64'd1);
    // An ack seen while holding must be ignored.
    imem_rdata = ~data;
    for (int i = 0; i < st; i++) begin
      stall = 1'b1;
      step();
      check("stall_valid", {63'd0, instr_valid}, 64'd1);
      check("stall_pc", {32'd0, pc}, {32'd0, exp_pc});
      check("stall_instr", {32'd0, instr}, {32'd0, data});
      check("stall_req", {63'd0, imem_req}, 64'd0);
    end
    imem_ack = 1'b0;
    stall    = 1'b0;
    step();
    check("release_valid", {63'd0, instr_valid}, 64'd0);
    exp_pc = exp_pc + 32'd4;
  endtask

  always @(negedge clk) begin
    if (instr_valid && !prev_valid) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected", 64'd1, 64'd0);
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        check("sb_pc", {32'd0, pc}, {32'd0, e[63:32]});
        check("sb_instr", {32'd0, instr}, {32'd0, e[31:0]});
        check("sb_op", {58'd0, op}, {58'd0, e[31:26]});
        check("sb_funct", {58'd0, funct}, {58'd0, e[5:0]});
        check("sb_pc_plus4", {32'd0, pc_plus4}, {32'd0, e[63:32] + 32'd4});
      end
    end
    prev_valid = instr_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    stall = 1'b0; redirect = 1'b0; redirect_target = '0;
    step();
    check("rst_valid", {63'd0, instr_valid}, 64'd0);
    check("rst_req", {63'd0, imem_req}, 64'd0);
    check("rst_pc", {32'd0, pc}, {32'd0, RPC});
    check("rst_instr", {32'd0, instr}, 64'd0);
    check("rst_err", {63'd0, fetch_err}, 64'd0);
    step();
    step();
    reset_n = 1'b1;
    // Redirect while in IDLE must be ignored.
    redirect = 1'b1; redirect_target = 32'h1234_5678;
    check("idle_valid", {63'd0, instr_valid}, 64'd0);
    check("idle_req", {63'd0, imem_req}, 64'd0);
    step();
    redirect = 1'b0;
    check("first_req", {63'd0, imem_req}, 64'd1);
    check("first_addr", {32'd0, imem_addr}, {32'd0, RPC});
    exp_pc = RPC;

    fetch_one(32'h8C08_0004, 0, 0);
    check("op_lw", {58'd0, op}, 64'b100011);
    fetch_one(32'h0109_5020, 0, 4);
    check("op_r", {58'd0, op}, 64'd0);
    check("funct_add", {58'd0, funct}, 64'b100000);
    fetch_one(32'h2108_0001, 3, 1);

    // Redirect in HOLD while stalled.
    wait_req();
    imem_ack = 1'b1; imem_rdata = 32'hAAAA_5555;
    sb_q.push_back({exp_pc, 32'hAAAA_5555});
    step();
    imem_ack = 1'b0;
    stall = 1'b1; redirect = 1'b1; redirect_target = 32'h0040_0103;
    step();
    stall = 1'b0; redirect = 1'b0;
    check("hredir_valid", {63'd0, instr_valid}, 64'd0);
    check("hredir_req", {63'd0, imem_req}, 64'd1);
    check("hredir_addr", {32'd0, imem_addr}, 64'h0040_0100);
    exp_pc = 32'h0040_0100;

    // Redirect coincident with ack: data dropped, target to the wrap point.
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    redirect = 1'b1; redirect_target = 32'hFFFF_FFFE;
    step();
    imem_ack = 1'b0; redirect = 1'b0;
    check("fredir_valid", {63'd0, instr_valid}, 64'd0);
    check("fredir_req", {63'd0, imem_req}, 64'd1);
    check("fredir_addr", {32'd0, imem_addr}, 64'hFFFF_FFFC);
    exp_pc = 32'hFFFF_FFFC;
    fetch_one(32'h2008_0001, 2, 0);
    check("wrap_addr", {32'd0, imem_addr}, 64'd0);
    fetch_one(32'h0000_000C, 0, 1);

`ifdef FETCH_TIMEOUT_EN
    sb_q.push_back({exp_pc, 32'h0});
    repeat (15) step();
    check("to_err_early", {63'd0, fetch_err}, 64'd0);
    check("to_valid_early", {63'd0, instr_valid}, 64'd0);
    step();
    check("to_err", {63'd0, fetch_err}, 64'd1);
    check("to_instr", {32'd0, instr}, 64'd0);
    check("to_valid", {63'd0, instr_valid}, 64'd1);
    step();
    check("to_err_sticky", {63'd0, fetch_err}, 64'd1);
    check("to_next_addr", {32'd0, imem_addr}, {32'd0, exp_pc + 32'd4});
`else
    repeat (20) step();
    check("noto_err", {63'd0, fetch_err}, 64'd0);
    check("noto_req", {63'd0, imem_req}, 64'd1);
    check("noto_valid", {63'd0, instr_valid}, 64'd0);
`endif

    reset_n = 1'b0;
    step();
    check("rst2_err", {63'd0, fetch_err}, 64'd0);
    check("rst2_req", {63'd0, imem_req}, 64'd0);
    check("rst2_pc", {32'd0, pc}, {32'd0, RPC});
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_fetch_unit.md
Name: mips_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the main decoder.
- Holds the PC and issues word reads to instruction memory over a req/ack handshake.
- Latches the returned instruction and presents the opcode, funct and fields to the controller; the decoder applies back-pressure via `stall`.
- Accepts branch/jump redirects from the datapath. Next-PC is PC+4 or a redirect target.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT_CYCLES, 16, cycles waited for imem_ack before a fetch error; used only with the optional feature.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- imem_req  out  1  fetch request; high only in state FETCH.
- imem_addr  out  32  word address; equals pc; bits [1:0] always 0.
- imem_ack  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  32  instruction word; valid only when imem_ack=1.
- stall  in  1  decoder not ready; holds the current instruction.
- redirect  in  1  branch taken or jump; load redirect_target.
- redirect_target  in  32  new PC; bits [1:0] ignored and forced to 0.
- instr_valid  out  1  instr/op/funct/pc valid.
- instr  out  32  latched instruction.
- op  out  6  instr[31:26], feeds the decoder opcode input.
- funct  out  6  instr[5:0].
- pc  out  32  address of the instruction in `instr`.
- pc_plus4  out  32  pc+4, mod 2^32.
- fetch_err  out  1  sticky fetch timeout flag; tied 0 when the optional feature is off.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - state=IDLE, pc=RESET_PC, instr=32'h0, instr_valid=0, fetch_err=0.
  - imem_req=0 whenever state≠FETCH.
- States: IDLE, FETCH, HOLD.
- IDLE:
  - Lasts exactly one cycle after reset release, then goes to FETCH.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ack=1 with redirect=0: instr<=imem_rdata, instr_valid<=1, go to HOLD. Latency is 1 cycle from ack to instr_valid.
  - On redirect=1: pc<={redirect_target[31:2],2'b00}; stay in FETCH; any same-cycle ack data is discarded. The next cycle requests the new address.
- HOLD:
  - instr_valid=1; outputs stay stable while stall=1.
  - stall=0, redirect=0: pc<=pc+4, instr_valid<=0, go to FETCH.
  - redirect=1, regardless of stall: pc<=aligned target, instr_valid<=0, go to FETCH. Redirect wins over stall.
- Arithmetic:
  - pc+4 wraps: 32'hFFFF_FFFC → 32'h0000_0000.
  - pc_plus4 is combinational from pc.
- Timing and ignored inputs:
  - Throughput without stalls or wait states: one instruction per 2 cycles (FETCH, HOLD).
  - imem_ack outside FETCH is ignored.
  - redirect in IDLE is ignored.
- Reset mid-operation:
  - Reset during FETCH or HOLD aborts immediately.
  - The outstanding request is abandoned and no instruction is delivered.
  - Memory must tolerate a dropped request.
- op/funct are slices of the `instr` register, so no extra latency is added.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- With it defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on FETCH entry and increments each FETCH cycle without ack.
  - When it reaches TIMEOUT_CYCLES, fetch_err<=1 (sticky until reset).
  - instr<=32'h0000_0000 (NOP), instr_valid<=1, go to HOLD. The pipeline proceeds at pc+4.
  - Redirect clears the counter.
- Without it:
  - No counter; FETCH waits indefinitely.
  - fetch_err is tied 0.

Test Plan:
- Reset sequence: hold reset_n=0 for 3 cycles with RESET_PC=32'h0040_0000, then release → instr_valid=0 and imem_req=0 in the first cycle; imem_req=1 with imem_addr=32'h0040_0000 in the next.
- Sequential fetch: memory acks in the same cycle with 32'h8C08_0004, then 32'h0109_5020 → op=6'b100011 then op=6'b000000, funct=6'b100000; pc goes 0x0040_0000 → 0x0040_0004.
- Stall hold: stall=1 for 4 cycles in HOLD → instr, pc and instr_valid unchanged; no imem_req; after stall=0 the next request is at pc+4.
- Redirect in HOLD with stall=1, redirect_target=32'h0040_0103 → next imem_addr=32'h0040_0100; held instruction dropped (instr_valid=0).
- Redirect coincident with ack in FETCH → data discarded, instr_valid stays 0, next request goes to the target; wrap case pc=32'hFFFF_FFFC, stall=0 → next addr 32'h0.
- FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack → after 16 FETCH cycles fetch_err=1, instr=0, instr_valid=1; fetch_err persists until reset_n=0.
